alu_op_issuer: RTL and testbench

Front end of the 16-bit ALU. Accepts binary-encoded operation commands over a valid/ready handshake and drives operands plus the 12-bit one-hot result select into the ALU datapath and its output mux. After a settle interval it captures the muxed result and returns it with flags over a second valid/ready handshake. Holds a 16-bit accumulator so operations can be chained.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_op_decode.sv | 34 +++
 rtl/alu_op_issuer.sv | 139 +++++++++++++
 tb/tb_alu_op_issuer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, one-hot result-mux selects, issuer state encoding.
package alu_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned SEL_BITS = 12;

    // Binary opcodes carried on cmd_op
    localparam logic [OP_W-1:0] OP_AND     = 4'd0;
    localparam logic [OP_W-1:0] OP_OR      = 4'd1;
    localparam logic [OP_W-1:0] OP_NOT     = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR     = 4'd3;
    localparam logic [OP_W-1:0] OP_NAND    = 4'd4;
    localparam logic [OP_W-1:0] OP_NOR     = 4'd5;
    localparam logic [OP_W-1:0] OP_XNOR    = 4'd6;
    localparam logic [OP_W-1:0] OP_ADD     = 4'd7;
    localparam logic [OP_W-1:0] OP_SUB     = 4'd8;
    localparam logic [OP_W-1:0] OP_SHRIGHT = 4'd9;
    localparam logic [OP_W-1:0] OP_SHLEFT  = 4'd10;
    localparam logic [OP_W-1:0] OP_CLEAR   = 4'd11;

    // One-hot selects for the ALU result mux (shared with the mux itself)
    localparam logic [SEL_BITS-1:0] SEL_AND     = 12'h001;
    localparam logic [SEL_BITS-1:0] SEL_OR      = 12'h002;
    localparam logic [SEL_BITS-1:0] SEL_NOT     = 12'h004;
    localparam logic [SEL_BITS-1:0] SEL_XOR     = 12'h008;
    localparam logic [SEL_BITS-1:0] SEL_NAND    = 12'h010;
    localparam logic [SEL_BITS-1:0] SEL_NOR     = 12'h020;
    localparam logic [SEL_BITS-1:0] SEL_XNOR    = 12'h040;
    localparam logic [SEL_BITS-1:0] SEL_ADD     = 12'h080;
    localparam logic [SEL_BITS-1:0] SEL_SUB     = 12'h100;
    localparam logic [SEL_BITS-1:0] SEL_SHRIGHT = 12'h200;
    localparam logic [SEL_BITS-1:0] SEL_SHLEFT  = 12'h400;
    localparam logic [SEL_BITS-1:0] SEL_CLEAR   = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: binary opcode -> one-hot ALU mux select plus legal flag.
// Ports:
//   op      : binary opcode
//   sel_c   : one-hot select, all-zero for illegal opcodes
//   legal_c : opcode is in the defined map
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]     op,
    output logic [SEL_BITS-1:0] sel_c,
    output logic                legal_c
);

    always_comb begin
        sel_c   = '0;
        legal_c = 1'b1;
        case (op)
            OP_AND:     sel_c = SEL_AND;
            OP_OR:      sel_c = SEL_OR;
            OP_NOT:     sel_c = SEL_NOT;
            OP_XOR:     sel_c = SEL_XOR;
            OP_NAND:    sel_c = SEL_NAND;
            OP_NOR:     sel_c = SEL_NOR;
            OP_XNOR:    sel_c = SEL_XNOR;
            OP_ADD:     sel_c = SEL_ADD;
            OP_SUB:     sel_c = SEL_SUB;
            OP_SHRIGHT: sel_c = SEL_SHRIGHT;
            OP_SHLEFT:  sel_c = SEL_SHLEFT;
            OP_CLEAR:   sel_c = SEL_CLEAR;
            default:    legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU front end: accepts opcode commands, drives operands and one-hot select to the
// ALU, captures the muxed result after SETTLE cycles and returns it with flags.
// Keeps an accumulator that can replace operand A for chained operations.
// Ports:
//   clk, reset_n                       : clock, async active-low reset
//   cmd_valid/cmd_ready                : command handshake
//   cmd_op, cmd_a, cmd_b, cmd_use_acc  : command payload
//   alu_a, alu_b, alu_sel              : registered operands and select to the ALU
//   alu_res                            : muxed ALU result
//   rsp_valid/rsp_ready                : response handshake
//   rsp_data, rsp_zero, rsp_err        : response payload
//   acc                                : accumulator
module alu_op_issuer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SEL_W  = 12,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc
);

    import alu_pkg::*;

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   alu_a_n, alu_b_n, rsp_data_n, acc_n;
    logic [SEL_W-1:0]   alu_sel_n;
    logic               rsp_zero_n, rsp_err_n;
    logic [WIDTH-1:0]   result_c;
    logic [SEL_BITS-1:0] dec_sel_c;
    logic               dec_legal_c;

    alu_op_decode u_decode (
        .op      (cmd_op),
        .sel_c   (dec_sel_c),
        .legal_c (dec_legal_c)
    );

    // CLEAR yields zero independent of whatever the mux presents
    assign result_c = (alu_sel == SEL_W'(SEL_CLEAR)) ? '0 : alu_res;

    // Next-state and next-output decode
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        alu_a_n    = alu_a;
        alu_b_n    = alu_b;
        alu_sel_n  = alu_sel;
        rsp_data_n = rsp_data;
        rsp_zero_n = rsp_zero;
        rsp_err_n  = rsp_err;
        acc_n      = acc;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (dec_legal_c) begin
                        alu_a_n   = cmd_use_acc ? acc : cmd_a;
                        alu_b_n   = cmd_b;
                        alu_sel_n = SEL_W'(dec_sel_c);
                        cnt_n     = CNT_W'(SETTLE - 1);
                        state_n   = ISSUE;
                    end else begin
                        // Illegal opcode bypasses the ALU entirely
                        rsp_data_n = '0;
                        rsp_err_n  = 1'b1;
                        rsp_zero_n = 1'b1;
                        state_n    = RESP;
                    end
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    rsp_data_n = result_c;
                    acc_n      = result_c;
                    rsp_err_n  = 1'b0;
                    rsp_zero_n = (result_c == '0);
                    alu_sel_n  = '0;
                    state_n    = RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; handshake outputs track the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            acc       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_sel   <= alu_sel_n;
            rsp_data  <= rsp_data_n;
            rsp_zero  <= rsp_zero_n;
            rsp_err   <= rsp_err_n;
            acc       <= acc_n;
            cmd_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == RESP);
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: one instance with SETTLE=1 driven by a
// behavioural ALU, one with SETTLE=3 driven by a constant alu_res.
module tb_alu_op_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        cmd_valid, cmd_ready, cmd_use_acc;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b, alu_a, alu_b, alu_res, rsp_data, acc;
    logic [11:0] alu_sel;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_err;

    logic        cmd_valid3, cmd_ready3, cmd_use_acc3;
    logic [3:0]  cmd_op3;
    logic [15:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_res3, rsp_data3, acc3;
    logic [11:0] alu_sel3;
    logic        rsp_valid3, rsp_ready3, rsp_zero3, rsp_err3;

    int tests = 0;
    int fails = 0;

    alu_op_issuer #(.WIDTH(16), .SEL_W(12), .SETTLE(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .acc(acc)
    );

    alu_op_issuer #(.WIDTH(16), .SEL_W(12), .SETTLE(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_use_acc(cmd_use_acc3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_res(alu_res3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_zero(rsp_zero3), .rsp_err(rsp_err3), .acc(acc3)
    );

    // Behavioural ALU; CLEAR deliberately returns garbage to prove the issuer forces zero
    always_comb begin
        case (alu_sel)
            12'h001: alu_res = alu_a & alu_b;
            12'h002: alu_res = alu_a | alu_b;
            12'h004: alu_res = ~alu_a;
            12'h008: alu_res = alu_a ^ alu_b;
            12'h010: alu_res = ~(alu_a & alu_b);
            12'h020: alu_res = ~(alu_a | alu_b);
            12'h040: alu_res = ~(alu_a ^ alu_b);
            12'h080: alu_res = alu_a + alu_b;
            12'h100: alu_res = alu_a - alu_b;
            12'h200: alu_res = alu_a >> alu_b[3:0];
            12'h400: alu_res = alu_a << alu_b[3:0];
            12'h800: alu_res = 16'hBEEF;
            default: alu_res = 16'hDEAD;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command to instance 'which' (1 or 3); report latency in cycles
    // from the accepting edge to rsp_valid, the select seen and how long it was held.
    task automatic send(input int which, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ua, output int lat,
                        output logic [11:0] sel, output int sel_cyc);
        logic rv;
        logic [11:0] s;
        @(negedge clk);
        if (which == 3) begin
            cmd_valid3 = 1'b1; cmd_op3 = op; cmd_a3 = a; cmd_b3 = b; cmd_use_acc3 = ua;
            check("ready_before_cmd3", 32'(cmd_ready3), 32'd1);
        end else begin
            cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
            check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        lat = 1; sel = '0; sel_cyc = 0;
        rv = (which == 3) ? rsp_valid3 : rsp_valid;
        while (!rv && lat < 20) begin
            s = (which == 3) ? alu_sel3 : alu_sel;
            if (s != '0) begin sel = s; sel_cyc++; end
            @(posedge clk); #1;
            lat++;
            rv = (which == 3) ? rsp_valid3 : rsp_valid;
        end
        check("rsp_valid_seen", 32'(rv), 32'd1);
    endtask

    // Accept the pending response with a one-cycle rsp_ready pulse
    task automatic complete(input int which);
        @(negedge clk);
        if (which == 3) rsp_ready3 = 1'b1; else rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; rsp_ready3 = 1'b0;
        if (which == 3) begin
            check("done_rsp_valid3", 32'(rsp_valid3), 32'd0);
            check("done_cmd_ready3", 32'(cmd_ready3), 32'd1);
        end else begin
            check("done_rsp_valid", 32'(rsp_valid), 32'd0);
            check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    int lat, sel_cyc;
    logic [11:0] sel;

    initial begin
        reset_n = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0; rsp_ready = 0;
        cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_use_acc3 = 0; rsp_ready3 = 0;
        alu_res3 = 16'hBEEF;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        reset_n = 1'b1;

        // ADD 0x1234 + 0x0101
        send(1, 4'd7, 16'h1234, 16'h0101, 1'b0, lat, sel, sel_cyc);
        check("add_lat", 32'(lat), 32'd2);
        check("add_sel", 32'(sel), 32'h080);
        check("add_sel_cycles", 32'(sel_cyc), 32'd1);
        check("add_data", 32'(rsp_data), 32'h1335);
        check("add_acc", 32'(acc), 32'h1335);
        check("add_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        check("add_sel_in_resp", 32'(alu_sel), 32'd0);
        complete(1);

        // SUB chained from the accumulator; cmd_a must be ignored
        send(1, 4'd8, 16'hFFFF, 16'h0335, 1'b1, lat, sel, sel_cyc);
        check("sub_alu_a", 32'(alu_a), 32'h1335);
        check("sub_alu_b", 32'(alu_b), 32'h0335);
        check("sub_sel", 32'(sel), 32'h100);
        check("sub_data", 32'(rsp_data), 32'h1000);
        check("sub_acc", 32'(acc), 32'h1000);
        complete(1);

        // Illegal opcode 13
        send(1, 4'd13, 16'h5555, 16'hAAAA, 1'b0, lat, sel, sel_cyc);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_sel_cycles", 32'(sel_cyc), 32'd0);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_zero", 32'(rsp_zero), 32'd1);
        check("ill_data", 32'(rsp_data), 32'd0);
        check("ill_acc", 32'(acc), 32'h1000);
        check("ill_alu_a_held", 32'(alu_a), 32'h1335);
        complete(1);

        // XOR with a stalled consumer
        send(1, 4'd3, 16'h00FF, 16'h0F0F, 1'b0, lat, sel, sel_cyc);
        check("xor_sel", 32'(sel), 32'h008);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'(rsp_data), 32'h0FF0);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_alu_sel", 32'(alu_sel), 32'd0);
            @(posedge clk); #1;
        end
        check("xor_err", 32'(rsp_err), 32'd0);
        complete(1);
        check("xor_acc", 32'(acc), 32'h0FF0);

        // AND with rsp_ready already high: single-cycle response
        @(negedge clk); rsp_ready = 1'b1;
        send(1, 4'd0, 16'hF0F0, 16'hFF00, 1'b0, lat, sel, sel_cyc);
        check("and_lat", 32'(lat), 32'd2);
        check("and_data", 32'(rsp_data), 32'hF000);
        @(posedge clk); #1;
        check("and_one_cycle_rsp", 32'(rsp_valid), 32'd0);
        check("and_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;

        // Reset asserted while in ISSUE
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 16'h00F0; cmd_b = 16'h000F; cmd_use_acc = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_issue_sel", 32'(alu_sel), 32'h002);
        reset_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(alu_sel), 32'd0);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        send(1, 4'd4, 16'hFFFF, 16'h00FF, 1'b0, lat, sel, sel_cyc);
        check("nand_sel", 32'(sel), 32'h010);
        check("nand_data", 32'(rsp_data), 32'hFF00);
        check("nand_acc", 32'(acc), 32'hFF00);
        complete(1);

        // SETTLE=3: ADD loads acc from alu_res, then CLEAR zeroes it
        send(3, 4'd7, 16'h0001, 16'h0002, 1'b0, lat, sel, sel_cyc);
        check("s3_add_lat", 32'(lat), 32'd4);
        check("s3_add_data", 32'(rsp_data3), 32'hBEEF);
        check("s3_add_acc", 32'(acc3), 32'hBEEF);
        complete(3);
        send(3, 4'd11, 16'h1111, 16'h2222, 1'b0, lat, sel, sel_cyc);
        check("s3_clr_sel", 32'(sel), 32'h800);
        check("s3_clr_sel_cycles", 32'(sel_cyc), 32'd3);
        check("s3_clr_lat", 32'(lat), 32'd4);
        check("s3_clr_data", 32'(rsp_data3), 32'd0);
        check("s3_clr_zero", 32'(rsp_zero3), 32'd1);
        check("s3_clr_err", 32'(rsp_err3), 32'd0);
        check("s3_clr_acc", 32'(acc3), 32'd0);
        complete(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
